xg_mem_arbiter: RTL and testbench

Two-client burst arbiter between the XenonGecko memory master (xgmm, client V) and the CPU data port (client C), feeding the single SDRAM controller port. It latches one-cycle request pulses and grants fixed priority to V, with a starvation bound for C. It issues one 4-word burst downstream at a time and steers ready/offset/data back to the granted client with zero added latency.

---
 rtl/xg_mem_pkg.sv | 11 +
 rtl/xg_arb_req_latch.sv | 23 ++
 rtl/xg_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_xg_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xg_mem_pkg.sv
// Shared types and constants for the XenonGecko memory arbiter.
package xg_mem_pkg;
  localparam int ADDR_W    = 24;
  localparam int DATA_W    = 16;
  localparam int BURST_LEN = 4;
  // Offset of the final word of a downstream burst.
  localparam logic [1:0] LAST_OFFSET = 2'(BURST_LEN - 1);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;
  typedef enum logic {CL_V = 1'b0, CL_C = 1'b1} client_t;
endpackage

// File: rtl/xg_arb_req_latch.sv
// Per-client pending flag: remembers a request pulse that was not granted
// on the cycle it arrived, until that client's burst completes.
module xg_arb_req_latch (
  input  logic clk_sys,
  input  logic rst,
  input  logic req,      // one-cycle request pulse from the client
  input  logic consume,  // request granted straight from idle this cycle
  input  logic clear,    // this client's burst completes this cycle
  output logic pend
);

  // Set on an ungranted pulse, drop on completion; a fresh pulse wins over a same-cycle clear.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
    end else if (req && !consume) begin
      pend <= 1'b1;
    end else if (clear) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/xg_mem_arbiter.sv
// Two-client burst arbiter: xgmm (V, fixed priority) and CPU data port (C,
// starvation-bounded) sharing one 4-word SDRAM controller port.
//
// Handshake: a client pulses x_req for one cycle with x_addr/x_wren valid and
// holds them until its burst ends. Each downstream sd_ready stroke moves one
// word; x_ready mirrors it to the granted client only, in the same cycle, and
// x_wdata must be valid whenever x_ready is high. The burst ends on the stroke
// carrying offset 3. sd_req is a one-cycle pulse per burst.
module xg_mem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int ADDR_W       = xg_mem_pkg::ADDR_W,
  parameter int DATA_W       = xg_mem_pkg::DATA_W
) (
  input  logic                clk_sys,
  input  logic                rst,
  input  logic                v_req,
  input  logic                v_wren,
  input  logic [ADDR_W-1:0]   v_addr,
  input  logic [DATA_W-1:0]   v_wdata,
  output logic                v_ready,
  output logic [1:0]          v_offset,
  output logic [DATA_W-1:0]   v_rdata,
  input  logic                c_req,
  input  logic                c_wren,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic [DATA_W-1:0]   c_wdata,
  output logic                c_ready,
  output logic [1:0]          c_offset,
  output logic [DATA_W-1:0]   c_rdata,
  output logic                sd_req,
  output logic                sd_wren,
  output logic [ADDR_W-1:0]   sd_addr,
  output logic [DATA_W-1:0]   sd_wdata,
  input  logic                sd_ready,
  input  logic [1:0]          sd_offset,
  input  logic [DATA_W-1:0]   sd_rdata,
  output logic                busy,
  output xg_mem_pkg::state_t  dbg_state
);
  import xg_mem_pkg::*;

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

  state_t     state_q, state_d;
  client_t    grant_q, winner;
  logic [3:0] streak_q;
  logic       v_pend, c_pend;
  logic       v_seen, c_seen;
  logic       issue, done;

  assign v_seen = v_req | v_pend;
  assign c_seen = c_req | c_pend;

  xg_arb_req_latch u_v_latch (
    .clk_sys (clk_sys),
    .rst     (rst),
    .req     (v_req),
    .consume (issue && (winner == CL_V)),
    .clear   (done && (grant_q == CL_V)),
    .pend    (v_pend)
  );

  xg_arb_req_latch u_c_latch (
    .clk_sys (clk_sys),
    .rst     (rst),
    .req     (c_req),
    .consume (issue && (winner == CL_C)),
    .clear   (done && (grant_q == CL_C)),
    .pend    (c_pend)
  );

  // Next state: pick a winner in idle, watch for the last word of a burst.
  always_comb begin
    state_d = state_q;
    winner  = CL_V;
    issue   = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (v_seen || c_seen) begin
          issue   = 1'b1;
          state_d = S_BURST;
          if (c_seen && (!v_seen || (streak_q == STREAK_MAX))) begin
            winner = CL_C;
          end
        end
      end
      S_BURST: begin
        if (sd_ready && (sd_offset == LAST_OFFSET)) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, grant and downstream command registers; command is captured on issue.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= CL_V;
      sd_req  <= 1'b0;
      sd_wren <= 1'b0;
      sd_addr <= '0;
    end else begin
      state_q <= state_d;
      sd_req  <= issue;
      if (issue) begin
        grant_q <= winner;
        sd_wren <= (winner == CL_C) ? c_wren : v_wren;
        sd_addr <= (winner == CL_C) ? c_addr : v_addr;
      end
    end
  end

  // Count V grants taken while C waits; C is forced through once it hits the limit.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else if (issue) begin
      if ((winner == CL_V) && c_seen) begin
        if (streak_q != STREAK_MAX) begin
          streak_q <= streak_q + 4'd1;
        end
      end else begin
        streak_q <= '0;
      end
    end
  end

  assign busy      = (state_q == S_BURST);
  assign dbg_state = state_q;
  assign sd_wdata  = (grant_q == CL_C) ? c_wdata : v_wdata;
  assign v_ready   = sd_ready & busy & (grant_q == CL_V);
  assign c_ready   = sd_ready & busy & (grant_q == CL_C);
  assign v_offset  = sd_offset;
  assign c_offset  = sd_offset;
  assign v_rdata   = sd_rdata;
  assign c_rdata   = sd_rdata;

endmodule

// File: tb/tb_xg_mem_arbiter.sv
// Bench for xg_mem_arbiter: directed scenarios plus a randomized phase, all
// checked cycle by cycle against a rule-level reference model.
module tb_xg_mem_arbiter;
  import xg_mem_pkg::*;

  localparam int SL = 2;
  localparam int AW = 24;
  localparam int DW = 16;

  // Clock and reset
  logic clk_sys = 1'b0;
  logic rst;
  always #5 clk_sys = ~clk_sys;

  logic          v_req, v_wren, c_req, c_wren;
  logic [AW-1:0] v_addr, c_addr, sd_addr;
  logic [DW-1:0] v_wdata, c_wdata, v_rdata, c_rdata, sd_wdata, sd_rdata;
  logic          v_ready, c_ready, sd_req, sd_wren, sd_ready, busy;
  logic [1:0]    v_offset, c_offset, sd_offset;
  state_t        dbg_state;

  xg_mem_arbiter #(.STARVE_LIMIT(SL), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_sys(clk_sys), .rst(rst),
    .v_req(v_req), .v_wren(v_wren), .v_addr(v_addr), .v_wdata(v_wdata),
    .v_ready(v_ready), .v_offset(v_offset), .v_rdata(v_rdata),
    .c_req(c_req), .c_wren(c_wren), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ready(c_ready), .c_offset(c_offset), .c_rdata(c_rdata),
    .sd_req(sd_req), .sd_wren(sd_wren), .sd_addr(sd_addr), .sd_wdata(sd_wdata),
    .sd_ready(sd_ready), .sd_offset(sd_offset), .sd_rdata(sd_rdata),
    .busy(busy), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  // Reference model: who is waiting, who owns the port, how long C has waited
  bit            m_busy, m_sdreq, m_vp, m_cp, m_wren;
  int            m_gnt;     // 0 = V, 1 = C
  int            m_vwait;   // V grants taken while C was waiting
  logic [AW-1:0] m_addr;
  bit            v_out, c_out;

  // Downstream controller emulation
  bit r_active, noise_en;
  int r_off, r_gap;

  // Scoreboard and event log
  int         gnt_log[$];
  logic [0:0] exp_q[$];
  int         cnt_vr, cnt_cr, sdreq_cyc, v_done_cyc, c_sdreq_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_sdreq = 0; m_vp = 0; m_cp = 0; m_wren = 0;
    m_gnt = 0; m_vwait = 0; m_addr = '0; v_out = 0; c_out = 0;
  endtask

  // Apply the arbitration rules to the inputs of the current cycle.
  task automatic model_step();
    bit vs, cs, fin, v_gets, c_gets;
    if (rst) begin
      model_reset();
      return;
    end
    vs = v_req | m_vp;
    cs = c_req | m_cp;
    fin = m_busy && sd_ready && (sd_offset == 2'd3);
    v_gets = 0;
    c_gets = 0;
    if (!m_busy && (vs || cs)) begin
      if (cs && (!vs || m_vwait >= SL)) c_gets = 1;
      else v_gets = 1;
    end
    if (v_req && !v_gets) m_vp = 1;
    else if (fin && m_gnt == 0) m_vp = 0;
    if (c_req && !c_gets) m_cp = 1;
    else if (fin && m_gnt == 1) m_cp = 0;
    if (fin && m_gnt == 0) v_out = 0;
    if (fin && m_gnt == 1) c_out = 0;
    m_sdreq = v_gets | c_gets;
    if (v_gets) begin
      m_gnt = 0; m_addr = v_addr; m_wren = v_wren;
      m_vwait = cs ? ((m_vwait < SL) ? m_vwait + 1 : SL) : 0;
    end
    if (c_gets) begin
      m_gnt = 1; m_addr = c_addr; m_wren = c_wren; m_vwait = 0;
    end
    if (v_gets || c_gets) m_busy = 1;
    else if (fin) m_busy = 0;
  endtask

  // One clock cycle: check outputs mid-cycle, advance model, drive next inputs.
  task automatic cyc();
    @(negedge clk_sys);
    cyc_n++;
    chk("busy", busy, m_busy);
    chk("dbg_state", dbg_state, m_busy ? S_BURST : S_IDLE);
    chk("sd_req", sd_req, m_sdreq);
    chk("sd_addr", sd_addr, m_addr);
    chk("sd_wren", sd_wren, m_wren);
    chk("v_ready", v_ready, sd_ready && m_busy && m_gnt == 0);
    chk("c_ready", c_ready, sd_ready && m_busy && m_gnt == 1);
    chk("v_offset", v_offset, sd_offset);
    chk("c_offset", c_offset, sd_offset);
    chk("v_rdata", v_rdata, sd_rdata);
    chk("c_rdata", c_rdata, sd_rdata);
    if (m_busy) chk("sd_wdata", sd_wdata, (m_gnt == 1) ? c_wdata : v_wdata);
    if (v_ready === 1'b1) cnt_vr++;
    if (c_ready === 1'b1) cnt_cr++;
    if (v_ready === 1'b1 && sd_offset == 2'd3) v_done_cyc = cyc_n;
    if (m_sdreq) gnt_log.push_back(m_gnt);
    if (sd_req === 1'b1) begin
      sdreq_cyc = cyc_n;
      if (m_gnt == 1) c_sdreq_cyc = cyc_n;
      r_active = 1; r_off = 0; r_gap = $urandom_range(0, 2);
    end
    model_step();
    @(posedge clk_sys);
    #1;
    v_req = 0;
    c_req = 0;
    sd_rdata = DW'($urandom);
    sd_ready = 0;
    if (rst) begin
      r_active = 0;
    end else if (r_active) begin
      if (r_gap > 0) begin
        r_gap--;
      end else begin
        sd_ready = 1; sd_offset = 2'(r_off); r_off++;
        r_gap = $urandom_range(0, 2);
        if (r_off == 4) r_active = 0;
      end
    end else if (noise_en && !m_busy && $urandom_range(0, 3) == 0) begin
      sd_ready = 1; sd_offset = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int n = 0;
    while ((m_busy || m_vp || m_cp || m_sdreq) && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, (n < budget), 1'b1);
  endtask

  initial begin
    int g0, n, vcnt, ccnt, vmade, cmade, snap_v, snap_c;
    bit found;
    rst = 1; noise_en = 0; r_active = 0;
    v_req = 0; v_wren = 0; v_addr = '0; v_wdata = '0;
    c_req = 0; c_wren = 0; c_addr = '0; c_wdata = '0;
    sd_ready = 0; sd_offset = '0; sd_rdata = '0;
    cnt_vr = 0; cnt_cr = 0; sdreq_cyc = 0; v_done_cyc = 0; c_sdreq_cyc = 0;
    model_reset();
    repeat (3) cyc();
    rst = 0;

    // V read issued at cycle 10
    while (cyc_n < 9) cyc();
    v_addr = 24'h000120; v_wren = 0; v_req = 1; v_out = 1;
    snap_v = cnt_vr; snap_c = cnt_cr;
    cyc();
    wait_quiet("t1_quiet", 40);
    chk("t1_sdreq_cycle", sdreq_cyc, 11);
    chk("t1_v_strokes", cnt_vr - snap_v, 4);
    chk("t1_c_strokes", cnt_cr - snap_c, 0);

    // C write
    c_addr = 24'h010040; c_wren = 1; c_wdata = 16'hA5A5; c_req = 1; c_out = 1;
    snap_v = cnt_vr; snap_c = cnt_cr;
    cyc();
    wait_quiet("t2_quiet", 40);
    chk("t2_c_strokes", cnt_cr - snap_c, 4);
    chk("t2_v_strokes", cnt_vr - snap_v, 0);
    chk("t2_grant", gnt_log[$], 1);

    // Simultaneous requests: V first, C two cycles after V's last word
    v_addr = 24'h000200; v_wren = 0; c_addr = 24'h010080; c_wren = 0;
    v_req = 1; c_req = 1; v_out = 1; c_out = 1;
    g0 = gnt_log.size();
    cyc();
    wait_quiet("t3_quiet", 60);
    chk("t3_count", gnt_log.size() - g0, 2);
    chk("t3_first", gnt_log[g0], 0);
    chk("t3_second", gnt_log[g0+1], 1);
    chk("t3_gap", c_sdreq_cyc - v_done_cyc, 2);

    // Starvation bound: V always asking, C asking twice
    v_addr = 24'h000300; c_addr = 24'h010300;
    exp_q = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    g0 = gnt_log.size();
    n = 0;
    while (gnt_log.size() - g0 < 6 && n < 400) begin
      v_req = !m_busy;
      c_req = !m_busy && ((gnt_log.size() - g0) == 0 || (gnt_log.size() - g0) == 3);
      cyc();
      n++;
    end
    wait_quiet("t4_quiet", 60);
    chk("t4_count_ok", (gnt_log.size() - g0 >= 6), 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (g0 + i < gnt_log.size()) chk($sformatf("t4_order%0d", i), gnt_log[g0+i], exp_q[i]);
    end

    // C pulses twice during a V burst: exactly one C burst follows
    v_addr = 24'h000400; c_addr = 24'h010400;
    g0 = gnt_log.size();
    v_req = 1; cyc(); cyc();
    c_req = 1; cyc(); cyc();
    c_req = 1; cyc();
    wait_quiet("t5_quiet", 60);
    chk("t5_count", gnt_log.size() - g0, 2);
    if (gnt_log.size() - g0 == 2) begin
      chk("t5_first", gnt_log[g0], 0);
      chk("t5_second", gnt_log[g0+1], 1);
    end

    // Randomized traffic with stray sd_ready strokes in idle
    noise_en = 1;
    g0 = gnt_log.size();
    vmade = 0; cmade = 0;
    repeat (1500) begin
      if (!v_out && $urandom_range(0, 3) == 0) begin
        v_addr = AW'($urandom); v_wren = 1'($urandom); v_req = 1; v_out = 1; vmade++;
      end
      if (!c_out && $urandom_range(0, 3) == 0) begin
        c_addr = AW'($urandom); c_wren = 1'($urandom); c_req = 1; c_out = 1; cmade++;
      end
      v_wdata = DW'($urandom);
      c_wdata = DW'($urandom);
      cyc();
    end
    wait_quiet("t6_quiet", 100);
    noise_en = 0;
    vcnt = 0; ccnt = 0;
    for (int i = g0; i < gnt_log.size(); i++) begin
      if (gnt_log[i] == 0) vcnt++;
      else ccnt++;
    end
    chk("t6_v_bursts", vcnt, vmade);
    chk("t6_c_bursts", ccnt, cmade);

    // Reset in the middle of a V burst
    v_addr = 24'h000777; v_wren = 1; v_req = 1; v_out = 1;
    cyc();
    found = 0; n = 0;
    while (!found && n < 30) begin
      cyc();
      n++;
      if (sd_ready && sd_offset == 2'd1 && m_busy && m_gnt == 0) found = 1;
    end
    chk("t7_found", found, 1'b1);
    #1 rst = 1;
    model_reset();
    r_active = 0;
    sd_ready = 0;
    #1;
    chk("t7_busy", busy, 1'b0);
    chk("t7_v_ready", v_ready, 1'b0);
    chk("t7_sd_req", sd_req, 1'b0);
    chk("t7_sd_addr", sd_addr, 24'h0);
    chk("t7_sd_wren", sd_wren, 1'b0);
    cyc(); cyc();
    rst = 0;
    cyc();
    v_addr = 24'h000888; v_wren = 0; v_req = 1; v_out = 1;
    snap_v = cnt_vr;
    cyc();
    wait_quiet("t7_quiet", 40);
    chk("t7_v_strokes", cnt_vr - snap_v, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
